// File: rtl/frogger_pkg.sv
// Shared types and defaults for the Frogger goal-row block.
package frogger_pkg;
  typedef enum logic {PLAY = 1'b0, FLASH = 1'b1} state_t;
  localparam logic [7:0] DEF_SLOT_MASK = 8'b00100100;
endpackage

// File: rtl/sc_blink_divider.sv
// Free-running clock divider: counts 0..BLINK_CYCLES-1 and pulses o_wrap on rollover.
module sc_blink_divider #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic i_gclk,
  input  logic i_grst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(BLINK_CYCLES - 1));
  // Clear wins over wrap so a cleared level restarts a full half-period.
  assign o_wrap = i_en & ~i_clr & w_last;

  always_ff @(posedge i_gclk or negedge i_grst_n) begin
    if (!i_grst_n)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/sc_reg_goal_frogger.sv
// Frogger goal row: tracks filled home slots, blinks empty ones, flashes on level complete.
module sc_reg_goal_frogger
  import frogger_pkg::*;
#(
  parameter int                  DATAWIDTH    = 8,
  parameter logic [DATAWIDTH-1:0] SLOT_MASK   = DEF_SLOT_MASK,
  parameter int                  BLINK_CYCLES = 25_000_000,
  parameter int                  DONE_FLASHES = 6
) (
  input  logic                           sc_reg_goal_frogger_CLOCK_50,
  input  logic                           sc_reg_goal_frogger_RESET_InLow,
  input  logic [DATAWIDTH-1:0]           sc_reg_goal_frogger_frogPos_InBUS,
  input  logic                           sc_reg_goal_frogger_arrive_In,
  input  logic                           sc_reg_goal_frogger_clear_In,
  output logic [DATAWIDTH-1:0]           sc_reg_goal_frogger_data_OutBUS,
  output logic [$clog2(DATAWIDTH+1)-1:0] sc_reg_goal_frogger_filled_OutBUS,
  output logic                           sc_reg_goal_frogger_home_Out,
  output logic                           sc_reg_goal_frogger_death_Out,
  output logic                           sc_reg_goal_frogger_levelDone_Out
);
  localparam int CNTW = $clog2(DATAWIDTH + 1);
  localparam int FW   = (DONE_FLASHES > 1) ? $clog2(DONE_FLASHES + 1) : 1;

  state_t               r_state, w_state_nxt;
  logic [DATAWIDTH-1:0] r_filled, w_filled_nxt;
  logic [DATAWIDTH-1:0] r_data, w_data_nxt;
  logic [CNTW-1:0]      r_count, w_count_nxt;
  logic [FW-1:0]        r_flash, w_flash_nxt;
  logic                 r_phase, w_phase_nxt;
  logic                 r_home, w_home_nxt;
  logic                 r_death, w_death_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_wrap, w_hit;

  sc_blink_divider #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .i_gclk   (sc_reg_goal_frogger_CLOCK_50),
    .i_grst_n (sc_reg_goal_frogger_RESET_InLow),
    .i_en     (1'b1),
    .i_clr    (sc_reg_goal_frogger_clear_In),
    .o_wrap   (w_wrap)
  );

  // A home needs exactly one frog column landing on a slot that is still empty.
  assign w_hit = $onehot(sc_reg_goal_frogger_frogPos_InBUS) &&
                 |(sc_reg_goal_frogger_frogPos_InBUS & SLOT_MASK & ~r_filled);

  always_comb begin
    w_state_nxt  = r_state;
    w_filled_nxt = r_filled;
    w_flash_nxt  = r_flash;
    w_phase_nxt  = r_phase ^ w_wrap;
    w_home_nxt   = 1'b0;
    w_death_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    if (sc_reg_goal_frogger_clear_In) begin
      w_state_nxt  = PLAY;
      w_filled_nxt = '0;
      w_flash_nxt  = '0;
      w_phase_nxt  = 1'b0;
    end else begin
      case (r_state)
        PLAY: if (sc_reg_goal_frogger_arrive_In) begin
          if (w_hit) begin
            w_filled_nxt = r_filled | sc_reg_goal_frogger_frogPos_InBUS;
            w_home_nxt   = 1'b1;
            if ((w_filled_nxt & SLOT_MASK) == SLOT_MASK) begin
              w_state_nxt = FLASH;
              w_flash_nxt = '0;
            end
          end else begin
            w_death_nxt = 1'b1;
          end
        end
        FLASH: if (w_wrap) begin
          if (r_flash == FW'(DONE_FLASHES - 1)) begin
            w_done_nxt   = 1'b1;
            w_filled_nxt = '0;
            w_flash_nxt  = '0;
            w_state_nxt  = PLAY;
          end else begin
            w_flash_nxt = r_flash + 1'b1;
          end
        end
        default: w_state_nxt = PLAY;
      endcase
    end
    // Even flash counts show the lit row, so FLASH always opens all-ones.
    if (w_state_nxt == FLASH)
      w_data_nxt = w_flash_nxt[0] ? '0 : '1;
    else
      w_data_nxt = ~SLOT_MASK | w_filled_nxt | (SLOT_MASK & {DATAWIDTH{w_phase_nxt}});
    w_count_nxt = CNTW'($countones(w_filled_nxt));
  end

  always_ff @(posedge sc_reg_goal_frogger_CLOCK_50 or negedge sc_reg_goal_frogger_RESET_InLow) begin
    if (!sc_reg_goal_frogger_RESET_InLow) begin
      r_state  <= PLAY;
      r_filled <= '0;
      r_flash  <= '0;
      r_phase  <= 1'b0;
      r_data   <= ~SLOT_MASK;
      r_count  <= '0;
      r_home   <= 1'b0;
      r_death  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_filled <= w_filled_nxt;
      r_flash  <= w_flash_nxt;
      r_phase  <= w_phase_nxt;
      r_data   <= w_data_nxt;
      r_count  <= w_count_nxt;
      r_home   <= w_home_nxt;
      r_death  <= w_death_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign sc_reg_goal_frogger_data_OutBUS    = r_data;
  assign sc_reg_goal_frogger_filled_OutBUS  = r_count;
  assign sc_reg_goal_frogger_home_Out       = r_home;
  assign sc_reg_goal_frogger_death_Out      = r_death;
  assign sc_reg_goal_frogger_levelDone_Out  = r_done;
endmodule

// File: tb/tb_sc_reg_goal_frogger.sv
// Scoreboard bench: stimulus queues expected pulses, a monitor checks each pulse as it appears.
module tb_sc_reg_goal_frogger;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pos = '0;
  logic       arrive = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic [3:0] filled;
  logic       home, death, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       home;
    logic       death;
    logic       done;
    logic [3:0] filled;
  } exp_t;
  exp_t exp_q[$];

  sc_reg_goal_frogger #(
    .DATAWIDTH(8), .SLOT_MASK(8'b00100100), .BLINK_CYCLES(4), .DONE_FLASHES(2)
  ) dut (
    .sc_reg_goal_frogger_CLOCK_50      (clk),
    .sc_reg_goal_frogger_RESET_InLow   (rst_n),
    .sc_reg_goal_frogger_frogPos_InBUS (pos),
    .sc_reg_goal_frogger_arrive_In     (arrive),
    .sc_reg_goal_frogger_clear_In      (clr),
    .sc_reg_goal_frogger_data_OutBUS   (data),
    .sc_reg_goal_frogger_filled_OutBUS (filled),
    .sc_reg_goal_frogger_home_Out      (home),
    .sc_reg_goal_frogger_death_Out     (death),
    .sc_reg_goal_frogger_levelDone_Out (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (home || death || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, home, death, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {29'd0, home, death, done}, {29'd0, e.home, e.death, e.done});
        chk("pulse_filled", {28'd0, filled}, {28'd0, e.filled});
      end
    end
  end

  task automatic do_arrive(input logic [7:0] p, input logic c);
    @(posedge clk); #1;
    pos = p; arrive = 1'b1; clr = c;
    @(posedge clk); #1;
    arrive = 1'b0; clr = 1'b0; pos = '0;
  endtask

  function automatic exp_t mk(input logic h, input logic d, input logic dn, input logic [3:0] f);
    exp_t e;
    e.home = h; e.death = d; e.done = dn; e.filled = f;
    return e;
  endfunction

  initial begin
    bit seen;
    // Reset state
    #12;
    chk("rst_data", {24'd0, data}, 32'h0000_00DB);
    chk("rst_filled", {28'd0, filled}, 32'd0);
    chk("rst_pulses", {29'd0, home, death, done}, 32'd0);

    // Blink after release: DB for edges 1..3, FF for 4..7, DB at 8
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), {24'd0, data}, ((i / 4) % 2) ? 32'hFF : 32'hDB);
    end
    chk("idle_filled", {28'd0, filled}, 32'd0);

    // First home at column 2
    exp_q.push_back(mk(1, 0, 0, 4'd1));
    do_arrive(8'b00000100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bit2_steady", {31'd0, data[2]}, 32'd1);
      chk("walls_lit", {24'd0, data & 8'hDB}, 32'hDB);
    end

    // Deaths: occupied slot, wall, zero, not one-hot
    exp_q.push_back(mk(0, 1, 0, 4'd1));
    do_arrive(8'b00000100, 1'b0);
    exp_q.push_back(mk(0, 1, 0, 4'd1));
    do_arrive(8'b00000001, 1'b0);
    exp_q.push_back(mk(0, 1, 0, 4'd1));
    do_arrive(8'b00000000, 1'b0);
    exp_q.push_back(mk(0, 1, 0, 4'd1));
    do_arrive(8'b00100100, 1'b0);
    @(negedge clk);
    chk("death_filled", {28'd0, filled}, 32'd1);

    // Last slot: home, flash FF then 00, then level done
    exp_q.push_back(mk(1, 0, 0, 4'd2));
    exp_q.push_back(mk(0, 0, 1, 4'd0));
    do_arrive(8'b00100000, 1'b0);
    @(negedge clk);
    chk("flash_start", {24'd0, data}, 32'hFF);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (data == 8'h00) seen = 1;
    end
    chk("flash_dark_seen", {31'd0, seen}, 32'd1);
    // Arrive during FLASH must be ignored
    do_arrive(8'b00000001, 1'b0);
    seen = done;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("level_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("post_done_filled", {28'd0, filled}, 32'd0);
    chk("post_done_walls", {24'd0, data & 8'hDB}, 32'hDB);
    exp_q.push_back(mk(1, 0, 0, 4'd1));
    do_arrive(8'b00000100, 1'b0);

    // Clear with simultaneous arrive: no pulse, everything empty
    do_arrive(8'b00100000, 1'b1);
    @(negedge clk);
    chk("clear_filled", {28'd0, filled}, 32'd0);
    chk("clear_data", {24'd0, data}, 32'hDB);
    repeat (3) @(negedge clk);

    // Reset mid-FLASH: no level done afterwards
    exp_q.push_back(mk(1, 0, 0, 4'd1));
    do_arrive(8'b00000100, 1'b0);
    exp_q.push_back(mk(1, 0, 0, 4'd2));
    do_arrive(8'b00100000, 1'b0);
    @(negedge clk);
    chk("flash2_start", {24'd0, data}, 32'hFF);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midflash_rst_data", {24'd0, data}, 32'hDB);
    chk("midflash_rst_filled", {28'd0, filled}, 32'd0);
    chk("midflash_rst_pulses", {29'd0, home, death, done}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sc_reg_goal_frogger.md
SC_REG_GOAL_FROGGER -- requirements
Module: sc_reg_goal_frogger

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8: goal-row width in LED columns.
REQ-002 SHALL have parameter SLOT_MASK, default 8'b00100100: columns that are home slots; all other columns are walls.
REQ-003 SHALL have parameter BLINK_CYCLES, default 25_000_000: empty-slot blink half-period in clocks.
REQ-004 SHALL have parameter DONE_FLASHES, default 6: row toggles shown after the last slot fills.
REQ-005 SHALL have port sc_reg_goal_frogger_CLOCK_50, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port sc_reg_goal_frogger_RESET_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port sc_reg_goal_frogger_frogPos_InBUS, input, DATAWIDTH bits: frog column, one-hot.
REQ-008 SHALL have port sc_reg_goal_frogger_arrive_In, input, 1 bit: one-clock strobe, frog reaches the goal row.
REQ-009 SHALL have port sc_reg_goal_frogger_clear_In, input, 1 bit: synchronous new-level clear.
REQ-010 SHALL have port sc_reg_goal_frogger_data_OutBUS, output, DATAWIDTH bits: registered row pattern.
REQ-011 SHALL have port sc_reg_goal_frogger_filled_OutBUS, output, $clog2(DATAWIDTH+1) bits: filled-slot count.
REQ-012 SHALL have port sc_reg_goal_frogger_home_Out, output, 1 bit: one-clock pulse, frog homed.
REQ-013 SHALL have port sc_reg_goal_frogger_death_Out, output, 1 bit: one-clock pulse, frog hit wall or occupied slot.
REQ-014 SHALL have port sc_reg_goal_frogger_levelDone_Out, output, 1 bit: one-clock pulse, level complete.

Function
REQ-015 FSM states SHALL be PLAY and FLASH; reset state is PLAY.
REQ-016 In PLAY, arrive_In with frogPos one-hot and hitting an unfilled SLOT_MASK bit SHALL set that filled bit and pulse home_Out the next clock.
REQ-017 In PLAY, arrive_In with frogPos on a wall, on a filled slot, zero, or not one-hot SHALL pulse death_Out the next clock and leave filled bits unchanged.
REQ-018 home_Out and death_Out SHALL never be asserted in the same clock.
REQ-019 filled_OutBUS SHALL equal the population count of filled bits, registered with them.
REQ-020 Blink counter SHALL count 0..BLINK_CYCLES-1, wrap to 0, and toggle blink phase on wrap.
REQ-021 In PLAY, data_OutBUS bit SHALL be 1 for walls and filled slots, and equal the blink phase for empty slots.
REQ-022 The arrive that fills the last slot SHALL pulse home_Out, move to FLASH, and reset the flash counter.
REQ-023 In FLASH, data_OutBUS SHALL toggle all-ones/all-zeros at each blink wrap, starting all-ones; arrive_In SHALL be ignored.
REQ-024 After DONE_FLASHES toggles, the block SHALL pulse levelDone_Out once, clear filled bits, and return to PLAY.
REQ-025 clear_In SHALL clear filled bits, blink counter, blink phase, and flash counter, and force PLAY next clock, in any state.
REQ-026 clear_In SHALL take priority over a simultaneous arrive_In; no home or death pulse results.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 Reset asserted SHALL immediately force PLAY, filled bits 0, counters 0, blink phase 0, all pulse outputs 0.
REQ-029 During reset data_OutBUS SHALL equal ~SLOT_MASK (walls lit, slots dark) and filled_OutBUS SHALL be 0.
REQ-030 Reset mid-FLASH SHALL abandon the flash sequence with no levelDone_Out pulse.

Structure
REQ-031 FSM state encodings and the default SLOT_MASK SHALL live in a shared package frogger_pkg.
REQ-032 The blink divider SHALL be one sub-module, sc_blink_divider, parameterised by BLINK_CYCLES, with enable, sync clear, and wrap-pulse output.

Verification (bench with BLINK_CYCLES=4, DONE_FLASHES=2, defaults otherwise)
REQ-033 Release reset, idle 8 clocks -> data toggles 8'b11011011/8'b11111111 every 4 clocks; filled=0.
REQ-034 arrive with frogPos=8'b00000100 -> home pulse 1 clock, filled=1, bit 2 steady 1.
REQ-035 Repeat arrive at 8'b00000100, then at 8'b00000001 -> two death pulses; filled stays 1.
REQ-036 arrive at 8'b00100000 -> home pulse, FLASH; data 8'hFF,8'h00 per 4 clocks; levelDone pulse; filled=0, PLAY.
REQ-037 clear_In and arrive at 8'b00100000 in the same clock -> no pulses, filled=0.
REQ-038 Reset asserted mid-FLASH -> data=8'b11011011 immediately; no levelDone pulse after release.
